rtib_core: RTL

Real-time input buffer. It is the capture-side counterpart of the timestamped output buffer. It samples 8 TTL inputs and detects changes on enabled channels. Each change is tagged with the 64-bit global counter and pushed as a 128-bit entry into a first-word-fall-through FIFO, which the CPU/AXI side drains. Overflow is reported with a one-cycle error pulse and a capture of the dropped entry.

---
 rtl/rtib_pkg.sv | 24 ++
 rtl/rtib_fifo.sv | 78 +++++++
 rtl/rtib_core.sv | 115 +++++++++++
 3 files changed

// File: rtl/rtib_pkg.sv
// Shared widths, entry layout and packing helper for the real-time input buffer.
package rtib_pkg;

    localparam int TS_W    = 64;
    localparam int CH_W    = 8;
    localparam int ENTRY_W = 128;
    localparam int PAD_W   = ENTRY_W - TS_W - CH_W;

    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [PAD_W-1:0] pad;
        logic [CH_W-1:0]  state;
    } rtib_entry_t;

    function automatic rtib_entry_t pack_entry(input logic [TS_W-1:0] ts,
                                               input logic [CH_W-1:0] state);
        rtib_entry_t e;
        e.ts    = ts;
        e.pad   = '0;
        e.state = state;
        return e;
    endfunction

endpackage

// File: rtl/rtib_fifo.sv
// First-word-fall-through FIFO over asynchronous-read distributed RAM.
// flush clears pointers/count and discards any same-cycle write or read.
module rtib_fifo #(
    parameter int DEPTH   = 64,
    parameter int ENTRY_W = 128,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush_i,
    input  logic               wr_en_i,
    input  logic [ENTRY_W-1:0] wr_data_i,
    input  logic               rd_en_i,
    output logic [ENTRY_W-1:0] rd_data_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               wr_accepted_o
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               empty;
    logic               rd_do;
    logic               wr_do;

    assign empty = (count_q == '0);
    assign rd_do = rd_en_i && !empty && !flush_i;
    // A pop in the same cycle frees a slot, so a write at full still lands.
    assign wr_do = wr_en_i && !flush_i && ((count_q != DEPTH_C) || rd_do);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_do) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_do) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({wr_do, rd_do})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_do) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o     = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o       = count_q;
    assign full_o        = (count_q == DEPTH_C);
    assign empty_o       = empty;
    assign wr_accepted_o = wr_do;

endmodule

// File: rtl/rtib_core.sv
// Real-time input buffer: samples TTL inputs, timestamps enabled-channel changes
// into a FWFT FIFO and captures dropped entries. RTIB_INPUT_SYNC_EN adds a 2-flop synchroniser.
module rtib_core
    import rtib_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               auto_start,
    input  logic               flush,
    input  logic [CH_W-1:0]    ttl_in,
    input  logic [CH_W-1:0]    channel_en,
    input  logic [TS_W-1:0]    counter,
    input  logic               rd_en,
    output logic [ENTRY_W-1:0] dout,
    output logic               empty,
    output logic               full,
    output logic [CNT_W-1:0]   count,
    output logic               overflow_error,
    output logic [ENTRY_W-1:0] overflow_error_data
);

    logic [CH_W-1:0]    s_cur;
    logic [CH_W-1:0]    s_prev_q;
    logic [CH_W-1:0]    chg;
    logic               evt;
    rtib_entry_t        entry;
    logic [ENTRY_W-1:0] entry_bits;
    logic               wr_accepted;
    logic               ovf_q, ovf_d;
    logic [ENTRY_W-1:0] ovf_data_q, ovf_data_d;

`ifdef RTIB_INPUT_SYNC_EN
    (* ASYNC_REG = "TRUE" *) logic [CH_W-1:0] sync1_q;
    (* ASYNC_REG = "TRUE" *) logic [CH_W-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ttl_in;
            sync2_q <= sync1_q;
        end
    end

    assign s_cur = sync2_q;
`else
    logic [CH_W-1:0] samp_q;

    always_ff @(posedge clk) begin
        if (reset) samp_q <= '0;
        else       samp_q <= ttl_in;
    end

    assign s_cur = samp_q;
`endif

    // s_prev tracks even while capture is disabled, so enabling never fires on stale state.
    always_ff @(posedge clk) begin
        if (reset) s_prev_q <= '0;
        else       s_prev_q <= s_cur;
    end

    generate
        for (genvar gi = 0; gi < CH_W; gi++) begin : g_chg
            assign chg[gi] = (s_cur[gi] ^ s_prev_q[gi]) & channel_en[gi];
        end
    endgenerate

    assign evt        = auto_start && (|chg);
    assign entry      = pack_entry(counter, s_cur);
    assign entry_bits = entry;

    rtib_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W),
        .CNT_W   (CNT_W)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (flush),
        .wr_en_i       (evt),
        .wr_data_i     (entry_bits),
        .rd_en_i       (rd_en),
        .rd_data_o     (dout),
        .count_o       (count),
        .full_o        (full),
        .empty_o       (empty),
        .wr_accepted_o (wr_accepted)
    );

    // A flushed event is discarded on purpose and is not an overflow.
    always_comb begin
        ovf_d      = evt && !wr_accepted && !flush;
        ovf_data_d = ovf_data_q;
        if (ovf_d) ovf_data_d = entry_bits;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q      <= 1'b0;
            ovf_data_q <= '0;
        end else begin
            ovf_q      <= ovf_d;
            ovf_data_q <= ovf_data_d;
        end
    end

    assign overflow_error      = ovf_q;
    assign overflow_error_data = ovf_data_q;

endmodule
